load_align_unit: RTL and testbench

//  Sequential load-data formatter between the M-stage memory port and W-stage writeback.

---
 rtl/load_align_unit_if.sv | 33 +++
 rtl/load_align_unit.sv | 161 ++++++++++++++++
 tb/tb_load_align_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// Bus bundle for load_align_unit: request port, synchronous RAM read port and response port.
// The master side is the request producer, which also plays the data RAM and consumes responses.
interface load_align_unit_if #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 32,
    parameter int unsigned TAGW = 5
);
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_addr;
    logic [2:0]      req_mode;
    logic [TAGW-1:0] req_tag;

    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [TAGW-1:0] rsp_tag;
    logic            rsp_err;

    modport master (
        output req_valid, req_addr, req_mode, req_tag, mem_rdata, rsp_ready,
        input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_mode, req_tag, mem_rdata, rsp_ready,
        output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_tag, rsp_err
    );
endinterface

// File: rtl/load_align_unit.sv
// Sequential load formatter: 1 or 2 reads from a 1-cycle synchronous RAM, little-endian byte
// extraction and zero/sign extension. Define UNALIGNED_EN to allow misaligned and word-crossing loads.
module load_align_unit #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 32,
    parameter int unsigned TAGW = 5
) (
    input  logic             clk,
    input  logic             reset,
    load_align_unit_if.slave bus
);
    localparam int unsigned B     = DW / 8;
    localparam int unsigned OW    = $clog2(B);
    localparam logic [OW:0] BYTES = (OW+1)'(B);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD0  = 3'd1;
    localparam logic [2:0] ST_RD1  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_RSP  = 3'd4;

`ifdef UNALIGNED_EN
    localparam bit ALLOW_MISALIGN = 1'b1;
`else
    localparam bit ALLOW_MISALIGN = 1'b0;
`endif

    // Reset asserts immediately, releases two clocks after the input deasserts.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    logic [2:0]      state;
    logic [OW-1:0]   off_q;
    logic [2:0]      mode_q;
    logic            split_q;
    logic [DW-1:0]   lo_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   rsp_data_q;
    logic [TAGW-1:0] rsp_tag_q;
    logic            rsp_err_q;

    function automatic logic [OW:0] size_of(input logic [2:0] mode);
        case (mode)
            3'd1, 3'd2: size_of = (OW+1)'(2);
            3'd3, 3'd4: size_of = (OW+1)'(1);
            3'd5, 3'd6: size_of = (OW+1)'(4);
            default:    size_of = BYTES;
        endcase
    endfunction

    logic [OW-1:0] req_off;
    logic [OW:0]   req_size;
    logic [OW:0]   req_mask;
    logic [OW:0]   req_end;
    logic          req_misaligned;
    logic          req_split;
    logic          req_bad;

    always_comb begin
        req_off        = bus.req_addr[OW-1:0];
        req_size       = size_of(bus.req_mode);
        req_mask       = req_size - (OW+1)'(1);
        req_misaligned = ({1'b0, req_off} & req_mask) != '0;
        req_end        = {1'b0, req_off} + req_size;
        req_split      = ALLOW_MISALIGN && (req_end > BYTES);
        req_bad        = (bus.req_mode == 3'd7) || (req_misaligned && !ALLOW_MISALIGN);
    end

    // Byte j of the result is byte (off+j) of the {hi, lo} pair.
    logic [2*DW-1:0] pair;
    logic [DW-1:0]   word;
    logic [DW-1:0]   keep;
    logic            sgn;
    logic [DW-1:0]   formatted;

    always_comb begin
        pair = split_q ? {bus.mem_rdata, lo_q} : {{DW{1'b0}}, bus.mem_rdata};
        word = DW'(pair >> {off_q, 3'b000});
        keep = '1;
        sgn  = 1'b0;
        case (mode_q)
            3'd1: begin keep = DW'(16'hFFFF);      sgn = word[15]; end
            3'd2: begin keep = DW'(16'hFFFF);                      end
            3'd3: begin keep = DW'(8'hFF);         sgn = word[7];  end
            3'd4: begin keep = DW'(8'hFF);                         end
            3'd5: begin keep = DW'(32'hFFFF_FFFF); sgn = word[31]; end
            3'd6: begin keep = DW'(32'hFFFF_FFFF);                 end
            default: ;
        endcase
        formatted = (word & keep) | (sgn ? ~keep : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            off_q      <= '0;
            mode_q     <= '0;
            split_q    <= 1'b0;
            lo_q       <= '0;
            mem_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        off_q     <= req_off;
                        mode_q    <= bus.req_mode;
                        split_q   <= req_split;
                        rsp_tag_q <= bus.req_tag;
                        if (req_bad) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            state      <= ST_RSP;
                        end else begin
                            mem_addr_q <= {bus.req_addr[AW-1:OW], {OW{1'b0}}};
                            rsp_err_q  <= 1'b0;
                            state      <= ST_RD0;
                        end
                    end
                end
                ST_RD0: begin
                    if (split_q) begin
                        mem_addr_q <= mem_addr_q + AW'(B);
                        state      <= ST_RD1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_RD1: begin
                    lo_q  <= bus.mem_rdata;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    rsp_data_q <= formatted;
                    state      <= ST_RSP;
                end
                ST_RSP: begin
                    if (bus.rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE) && rst_n;
    assign bus.mem_rd_en = (state == ST_RD0) || (state == ST_RD1);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.rsp_valid = (state == ST_RSP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: directed vector table, stall/reset sequences, a DW=64 instance,
// and random loads checked against a byte-level reference model.
module tb_load_align_unit;
`ifdef UNALIGNED_EN
    localparam bit UNALIGNED = 1'b1;
`else
    localparam bit UNALIGNED = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    load_align_unit_if #(.DW(32), .AW(32), .TAGW(5)) bus32 ();
    load_align_unit_if #(.DW(64), .AW(32), .TAGW(5)) bus64 ();

    load_align_unit #(.DW(32), .AW(32), .TAGW(5)) dut32 (.clk(clk), .reset(rst_n), .bus(bus32));
    load_align_unit #(.DW(64), .AW(32), .TAGW(5)) dut64 (.clk(clk), .reset(rst_n), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAMs: request sampled mid-cycle, data appears after the next rising edge.
    logic [31:0] mem32 [0:255];
    logic [63:0] mem64 [0:63];
    logic        pend32_en, pend64_en;
    logic [31:0] pend32_addr, pend64_addr;
    logic [31:0] rd_log[$];

    always @(negedge clk) begin
        pend32_en   = bus32.mem_rd_en;
        pend32_addr = bus32.mem_addr;
        pend64_en   = bus64.mem_rd_en;
        pend64_addr = bus64.mem_addr;
        if (bus32.mem_rd_en === 1'b1) rd_log.push_back(bus32.mem_addr);
    end

    always @(posedge clk) begin
        if (pend32_en === 1'b1) bus32.mem_rdata <= mem32[pend32_addr[9:2]];
        if (pend64_en === 1'b1) bus64.mem_rdata <= mem64[pend64_addr[8:3]];
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] s;
        s = mem32[a[9:2]] >> {a[1:0], 3'b000};
        return s[7:0];
    endfunction

    task automatic model(input logic [31:0] addr, input logic [2:0] mode, output logic [31:0] data,
                         output bit err, output int lat, output int nrd);
        int          n;
        int          o;
        logic [31:0] v;
        logic [31:0] t;
        case (mode)
            3'd1, 3'd2: n = 2;
            3'd3, 3'd4: n = 1;
            default:    n = 4;
        endcase
        o   = int'(addr[1:0]);
        err = (mode == 3'd7) || (((o % n) != 0) && !UNALIGNED);
        if (err) begin
            data = '0; lat = 1; nrd = 0;
            return;
        end
        v = '0;
        for (int j = 0; j < n; j++) v = v | (32'(byte_at(addr + 32'(j))) << (8 * j));
        t = v >> (8 * n - 1);
        if ((mode == 3'd1 || mode == 3'd3 || mode == 3'd5) && t[0]) v = v | (32'hFFFF_FFFF << (8 * n));
        data = v;
        lat  = (o + n > 4) ? 4 : 3;
        nrd  = (o + n > 4) ? 2 : 1;
    endtask

    task automatic run_load(input string name, input logic [31:0] addr, input logic [2:0] mode,
                            input logic [4:0] tag, input int stall, input logic [31:0] exp_data,
                            input bit exp_err, input int exp_lat, input int exp_nrd);
        int          lat;
        logic [31:0] base;
        lat  = 0;
        base = addr & 32'hFFFF_FFFC;
        rd_log.delete();
        @(negedge clk);
        check({name, ".req_ready"}, 64'(bus32.req_ready), 64'd1);
        bus32.req_valid = 1'b1;
        bus32.req_addr  = addr;
        bus32.req_mode  = mode;
        bus32.req_tag   = tag;
        bus32.rsp_ready = (stall == 0);
        @(posedge clk);
        #1 bus32.req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus32.rsp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        check({name, ".latency"}, 64'(lat), 64'(exp_lat));
        if (lat == 0) return;
        check({name, ".data"}, 64'(bus32.rsp_data), 64'(exp_data));
        check({name, ".err"}, 64'(bus32.rsp_err), 64'(exp_err));
        check({name, ".tag"}, 64'(bus32.rsp_tag), 64'(tag));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({name, ".hold_valid"}, 64'(bus32.rsp_valid), 64'd1);
            check({name, ".hold_req_ready"}, 64'(bus32.req_ready), 64'd0);
            check({name, ".hold_data"}, 64'(bus32.rsp_data), 64'(exp_data));
            check({name, ".hold_err"}, 64'(bus32.rsp_err), 64'(exp_err));
            check({name, ".hold_tag"}, 64'(bus32.rsp_tag), 64'(tag));
        end
        bus32.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, ".valid_drop"}, 64'(bus32.rsp_valid), 64'd0);
        check({name, ".back_idle"}, 64'(bus32.req_ready), 64'd1);
        bus32.rsp_ready = 1'b0;
        check({name, ".num_reads"}, 64'(rd_log.size()), 64'(exp_nrd));
        for (int i = 0; i < rd_log.size() && i < exp_nrd; i++)
            check({name, ".read_addr"}, 64'(rd_log[i]), 64'(base + 32'(4 * i)));
    endtask

    task automatic run_load64(input string name, input logic [31:0] addr, input logic [2:0] mode,
                              input logic [63:0] exp_data, input bit exp_err, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        bus64.req_valid = 1'b1;
        bus64.req_addr  = addr;
        bus64.req_mode  = mode;
        bus64.req_tag   = 5'h0A;
        @(posedge clk);
        #1 bus64.req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus64.rsp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        check({name, ".latency"}, 64'(lat), 64'(exp_lat));
        if (lat == 0) return;
        check({name, ".data"}, bus64.rsp_data, exp_data);
        check({name, ".err"}, 64'(bus64.rsp_err), 64'(exp_err));
    endtask

    typedef struct {
        string       name;
        logic [31:0] w100;
        logic [31:0] w104;
        logic [31:0] addr;
        logic [2:0]  mode;
        logic [4:0]  tag;
        logic [31:0] data;
        bit          err;
        int          lat;
        int          nrd;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [31:0] w100, input logic [31:0] w104,
                                input logic [31:0] addr, input logic [2:0] mode, input logic [4:0] tag,
                                input logic [31:0] data, input bit err, input int lat, input int nrd);
        vec_t v;
        v.name = name; v.w100 = w100; v.w104 = w104; v.addr = addr; v.mode = mode; v.tag = tag;
        v.data = data; v.err = err; v.lat = lat; v.nrd = nrd;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] edata;
        logic [2:0]  mode;
        bit          eerr;
        int          elat;
        int          enrd;
        bit          saw_valid;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus32.req_valid = 1'b0; bus32.req_addr = '0; bus32.req_mode = '0; bus32.req_tag = '0;
        bus32.rsp_ready = 1'b0;
        bus64.req_valid = 1'b0; bus64.req_addr = '0; bus64.req_mode = '0; bus64.req_tag = '0;
        bus64.rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem32[i] = '0;
        for (int i = 0; i < 64; i++) mem64[i] = '0;

        repeat (3) @(negedge clk);
        check("reset.req_ready", 64'(bus32.req_ready), 64'd0);
        check("reset.rsp_valid", 64'(bus32.rsp_valid), 64'd0);
        check("reset.mem_rd_en", 64'(bus32.mem_rd_en), 64'd0);
        check("reset.mem_addr", 64'(bus32.mem_addr), 64'd0);
        check("reset.rsp_data", 64'(bus32.rsp_data), 64'd0);
        check("reset.rsp_tag", 64'(bus32.rsp_tag), 64'd0);
        check("reset.rsp_err", 64'(bus32.rsp_err), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        vecs.push_back(mk("bs_101", 32'h8899AABB, 32'h0, 32'h101, 3'd3, 5'd1, 32'hFFFFFFAA, 0, 3, 1));
        vecs.push_back(mk("hu_102", 32'h8899AABB, 32'h0, 32'h102, 3'd2, 5'd2, 32'h00008899, 0, 3, 1));
        vecs.push_back(mk("hs_102", 32'h8899AABB, 32'h0, 32'h102, 3'd1, 5'd3, 32'hFFFF8899, 0, 3, 1));
        vecs.push_back(mk("bu_100", 32'h8899AABB, 32'h0, 32'h100, 3'd4, 5'd4, 32'h000000BB, 0, 3, 1));
        vecs.push_back(mk("full_100", 32'h8899AABB, 32'h0, 32'h100, 3'd0, 5'd5, 32'h8899AABB, 0, 3, 1));
        vecs.push_back(mk("mode7_100", 32'h8899AABB, 32'h0, 32'h100, 3'd7, 5'h1F, 32'h0, 1, 1, 0));
        vecs.push_back(mk("hu_101", 32'h8899AABB, 32'h0, 32'h101, 3'd2, 5'd6,
                          UNALIGNED ? 32'h000099AA : 32'h0, !UNALIGNED, UNALIGNED ? 3 : 1, UNALIGNED ? 1 : 0));
        vecs.push_back(mk("full_103", 32'h44332211, 32'h88776655, 32'h103, 3'd0, 5'd7,
                          UNALIGNED ? 32'h77665544 : 32'h0, !UNALIGNED, UNALIGNED ? 4 : 1, UNALIGNED ? 2 : 0));
        vecs.push_back(mk("hs_103", 32'h44332211, 32'h88776655, 32'h103, 3'd1, 5'd8,
                          UNALIGNED ? 32'h00005544 : 32'h0, !UNALIGNED, UNALIGNED ? 4 : 1, UNALIGNED ? 2 : 0));
        vecs.push_back(mk("bs_107", 32'h44332211, 32'h88776655, 32'h107, 3'd3, 5'd9, 32'hFFFFFF88, 0, 3, 1));
        vecs.push_back(mk("bu_106", 32'h44332211, 32'h88776655, 32'h106, 3'd4, 5'd10, 32'h00000077, 0, 3, 1));
        vecs.push_back(mk("hu_106", 32'h44332211, 32'h88776655, 32'h106, 3'd2, 5'd11, 32'h00008877, 0, 3, 1));
        vecs.push_back(mk("hs_106", 32'h44332211, 32'h88776655, 32'h106, 3'd1, 5'd12, 32'hFFFF8877, 0, 3, 1));
        vecs.push_back(mk("wu_104", 32'h44332211, 32'h88776655, 32'h104, 3'd6, 5'd13, 32'h88776655, 0, 3, 1));
        vecs.push_back(mk("ws_104", 32'h44332211, 32'h88776655, 32'h104, 3'd5, 5'd14, 32'h88776655, 0, 3, 1));

        foreach (vecs[i]) begin
            mem32[8'h40] = vecs[i].w100;
            mem32[8'h41] = vecs[i].w104;
            run_load(vecs[i].name, vecs[i].addr, vecs[i].mode, vecs[i].tag, 0,
                     vecs[i].data, vecs[i].err, vecs[i].lat, vecs[i].nrd);
        end

        // Response held for five cycles with rsp_ready low.
        mem32[8'h40] = 32'h44332211;
        run_load("stall_full", 32'h100, 3'd0, 5'h15, 5, 32'h44332211, 0, 3, 1);
        run_load("stall_err", 32'h100, 3'd7, 5'h16, 5, 32'h0, 1, 1, 0);
        run_load("stall_bs", 32'h103, 3'd3, 5'h17, 2, 32'h00000044, 0, 3, 1);

        // Reset asserted while the unit waits on RAM data; rsp_data is nonzero beforehand.
        mem32[8'h40] = 32'hCAFEF00D;
        @(negedge clk);
        bus32.req_valid = 1'b1; bus32.req_addr = 32'h100; bus32.req_mode = 3'd0; bus32.req_tag = 5'h03;
        bus32.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus32.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_wait.rsp_valid", 64'(bus32.rsp_valid), 64'd0);
        check("rst_wait.mem_rd_en", 64'(bus32.mem_rd_en), 64'd0);
        check("rst_wait.rsp_data", 64'(bus32.rsp_data), 64'd0);
        check("rst_wait.req_ready", 64'(bus32.req_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus32.rsp_valid === 1'b1) saw_valid = 1'b1;
        end
        check("rst_wait.lost_rsp", 64'(saw_valid), 64'd0);
        bus32.rsp_ready = 1'b0;
        run_load("after_reset", 32'h100, 3'd0, 5'h04, 0, 32'hCAFEF00D, 0, 3, 1);

        // 64-bit instance.
        mem64[6'h20] = 64'h80000000_00000000;
        mem64[6'h21] = 64'h11223344_55667788;
        run_load64("dw64_ws_104", 32'h104, 3'd5, 64'hFFFFFFFF_80000000, 0, 3);
        run_load64("dw64_wu_104", 32'h104, 3'd6, 64'h00000000_80000000, 0, 3);
        run_load64("dw64_full_100", 32'h100, 3'd0, 64'h80000000_00000000, 0, 3);
        run_load64("dw64_hs_106", 32'h106, 3'd1, 64'hFFFFFFFF_FFFF8000, 0, 3);
        run_load64("dw64_full_104", 32'h104, 3'd0,
                   UNALIGNED ? 64'h55667788_80000000 : 64'h0, !UNALIGNED, UNALIGNED ? 4 : 1);

        // Random loads against the byte-level model, including addresses that wrap past 2^32.
        for (int i = 0; i < 256; i++) mem32[i] = $urandom();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            else                           addr = 32'($urandom_range(0, 32'h3FF));
            mode = 3'($urandom_range(0, 7));
            model(addr, mode, edata, eerr, elat, enrd);
            run_load("rand", addr, mode, 5'($urandom_range(0, 31)), $urandom_range(0, 2),
                     edata, eerr, elat, enrd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
